// File: rtl/modulo_exponent_if.sv
// Start/finished handshake bus between the modular exponentiator (master)
// and the shift-add modular multiplier (slave).
interface modulo_exponent_if #(
    parameter int MAX_BITS = 256
);
    logic                mul_start;
    logic [1:0]          mul_mode;
    logic [MAX_BITS-1:0] mul_n;
    logic [MAX_BITS-1:0] mul_a;
    logic [MAX_BITS-1:0] mul_b;
    logic [MAX_BITS-1:0] mul_result;
    logic                mul_finished;

    modport master (
        output mul_start, mul_mode, mul_n, mul_a, mul_b,
        input  mul_result, mul_finished
    );

    modport slave (
        input  mul_start, mul_mode, mul_n, mul_a, mul_b,
        output mul_result, mul_finished
    );
endinterface

// File: rtl/modulo_exponent.sv
// Right-to-left square-and-multiply modular exponentiator computing a^e mod n;
// every product and square is delegated to the external modular multiplier.
module modulo_exponent #(
    parameter int MAX_BITS = 256,
    parameter int MAX_REG  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_n,
    input  logic [MAX_BITS-1:0] i_a,
    input  logic [MAX_BITS-1:0] i_e,
    modulo_exponent_if.master   mul_if,
    output logic [MAX_BITS-1:0] o_result,
    output logic                o_busy,
    output logic                o_finished
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_MUL_ISSUE = 3'd2,
        ST_MUL_WAIT  = 3'd3,
        ST_SQR_ISSUE = 3'd4,
        ST_SQR_WAIT  = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [MAX_BITS-1:0] ZERO_C  = {MAX_BITS{1'b0}};
    localparam logic [MAX_BITS-1:0] ONE_C   = {{(MAX_BITS-1){1'b0}}, 1'b1};
    localparam logic [MAX_REG-1:0]  K_ZERO_C = {MAX_REG{1'b0}};
    localparam logic [MAX_REG-1:0]  K_ONE_C  = {{(MAX_REG-1){1'b0}}, 1'b1};

    // Index of the most significant exponent bit scanned for an operand size.
    function automatic logic [MAX_REG-1:0] top_bit(input logic [1:0] mode);
        logic [MAX_REG-1:0] idx;
        case (mode)
            2'b00:   idx = MAX_REG'(8'd31);
            2'b01:   idx = MAX_REG'(8'd63);
            2'b10:   idx = MAX_REG'(8'd127);
            default: idx = MAX_REG'(8'd255);
        endcase
        return idx;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          mode_r, mode_s;
    logic [MAX_BITS-1:0] n_r, n_s;
    logic [MAX_BITS-1:0] e_r, e_s;
    logic [MAX_BITS-1:0] base_r, base_s;
    logic [MAX_BITS-1:0] acc_r, acc_s;
    logic [MAX_REG-1:0]  bit_num_r, bit_num_s;
    logic [MAX_REG-1:0]  k_r, k_s;
    logic [MAX_BITS-1:0] mul_a_r, mul_a_s;
    logic [MAX_BITS-1:0] mul_b_r, mul_b_s;
    logic                mul_start_r, mul_start_s;
    logic [MAX_BITS-1:0] result_r, result_s;
    logic                busy_r, busy_s;
    logic                finished_r, finished_s;

    // Next-state and next-output logic; outputs are registered so each pulse
    // is raised on entry to the state that owns it.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        n_s         = n_r;
        e_s         = e_r;
        base_s      = base_r;
        acc_s       = acc_r;
        bit_num_s   = bit_num_r;
        k_s         = k_r;
        mul_a_s     = mul_a_r;
        mul_b_s     = mul_b_r;
        mul_start_s = 1'b0;
        result_s    = result_r;
        busy_s      = busy_r;
        finished_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    mode_s    = i_mode;
                    n_s       = i_n;
                    e_s       = i_e;
                    bit_num_s = top_bit(i_mode);
                    base_s    = i_a;
                    acc_s     = (i_n == ONE_C) ? ZERO_C : ONE_C;
                    k_s       = K_ZERO_C;
                    busy_s    = 1'b1;
                    state_s   = ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (e_r[k_r]) begin
                    mul_a_s     = acc_r;
                    mul_b_s     = base_r;
                    mul_start_s = 1'b1;
                    state_s     = ST_MUL_ISSUE;
                end else if (k_r == bit_num_r) begin
                    result_s   = acc_r;
                    finished_s = 1'b1;
                    busy_s     = 1'b0;
                    state_s    = ST_DONE;
                end else begin
                    mul_a_s     = base_r;
                    mul_b_s     = base_r;
                    mul_start_s = 1'b1;
                    state_s     = ST_SQR_ISSUE;
                end
            end
            ST_MUL_ISSUE: begin
                state_s = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_if.mul_finished) begin
                    acc_s = mul_if.mul_result;
                    // The top bit is never followed by a square.
                    if (k_r == bit_num_r) begin
                        result_s   = mul_if.mul_result;
                        finished_s = 1'b1;
                        busy_s     = 1'b0;
                        state_s    = ST_DONE;
                    end else begin
                        mul_a_s     = base_r;
                        mul_b_s     = base_r;
                        mul_start_s = 1'b1;
                        state_s     = ST_SQR_ISSUE;
                    end
                end else begin
                    state_s = ST_MUL_WAIT;
                end
            end
            ST_SQR_ISSUE: begin
                state_s = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                if (mul_if.mul_finished) begin
                    base_s  = mul_if.mul_result;
                    k_s     = k_r + K_ONE_C;
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SQR_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'b00;
            n_r         <= ZERO_C;
            e_r         <= ZERO_C;
            base_r      <= ZERO_C;
            acc_r       <= ZERO_C;
            bit_num_r   <= K_ZERO_C;
            k_r         <= K_ZERO_C;
            mul_a_r     <= ZERO_C;
            mul_b_r     <= ZERO_C;
            mul_start_r <= 1'b0;
            result_r    <= ZERO_C;
            busy_r      <= 1'b0;
            finished_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            n_r         <= n_s;
            e_r         <= e_s;
            base_r      <= base_s;
            acc_r       <= acc_s;
            bit_num_r   <= bit_num_s;
            k_r         <= k_s;
            mul_a_r     <= mul_a_s;
            mul_b_r     <= mul_b_s;
            mul_start_r <= mul_start_s;
            result_r    <= result_s;
            busy_r      <= busy_s;
            finished_r  <= finished_s;
        end
    end

    assign mul_if.mul_start = mul_start_r;
    assign mul_if.mul_mode  = mode_r;
    assign mul_if.mul_n     = n_r;
    assign mul_if.mul_a     = mul_a_r;
    assign mul_if.mul_b     = mul_b_r;
    assign o_result         = result_r;
    assign o_busy           = busy_r;
    assign o_finished       = finished_r;
endmodule

// File: tb/tb_modulo_exponent.sv
// Self-checking bench for modulo_exponent: directed cases plus randomized
// 64-bit cases against a left-to-right modexp reference and a random-latency multiplier.
module tb_modulo_exponent;
    localparam int MB = 256;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    i_mode = 2'b00;
    logic [MB-1:0] i_n = '0;
    logic [MB-1:0] i_a = '0;
    logic [MB-1:0] i_e = '0;
    logic [MB-1:0] o_result;
    logic          o_busy;
    logic          o_finished;

    modulo_exponent_if #(.MAX_BITS(MB)) mul_if ();

    modulo_exponent #(.MAX_BITS(MB), .MAX_REG(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .i_n        (i_n),
        .i_a        (i_a),
        .i_e        (i_e),
        .mul_if     (mul_if),
        .o_result   (o_result),
        .o_busy     (o_busy),
        .o_finished (o_finished)
    );

    always #5 i_clk = ~i_clk;

    int compared   = 0;
    int mismatched = 0;

    // Multiplier model knobs (written by the stimulus, read by the model).
    int min_lat   = 1;
    int max_lat   = 3;
    bit allow_big = 1'b0;

    // Multiplier model bookkeeping (written only by the model).
    int            start_total = 0;
    int            overlap_err = 0;
    int            stable_err  = 0;
    logic          outstanding = 1'b0;
    int            lat_cnt     = 0;
    logic [MB-1:0] lat_a, lat_b, lat_n;

    function automatic logic [MB-1:0] mulmod(input logic [MB-1:0] x, input logic [MB-1:0] y,
                                             input logic [MB-1:0] m);
        logic [2*MB-1:0] xx, yy, mm, p;
        xx = {{MB{1'b0}}, x};
        yy = {{MB{1'b0}}, y};
        mm = {{MB{1'b0}}, m};
        p  = (xx * yy) % mm;
        return p[MB-1:0];
    endfunction

    // Left-to-right reference: scan exponent bits top..0.
    function automatic logic [MB-1:0] modexp(input logic [MB-1:0] n, input logic [MB-1:0] a,
                                             input logic [MB-1:0] e, input int top);
        logic [MB-1:0] r;
        r = (n == 1) ? '0 : MB'(1);
        for (int i = top; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (e[i]) r = mulmod(r, a, n);
        end
        return r;
    endfunction

    // Modular multiplier model with random completion latency; shares the reset.
    always @(negedge i_clk) begin
        logic was_out;
        mul_if.mul_finished = 1'b0;
        if (!i_rst) begin
            outstanding = 1'b0;
            lat_cnt     = 0;
        end else begin
            was_out = outstanding;
            if (outstanding) begin
                if (mul_if.mul_a !== lat_a || mul_if.mul_b !== lat_b) stable_err++;
                if (lat_cnt == 0) begin
                    mul_if.mul_finished = 1'b1;
                    mul_if.mul_result   = mulmod(lat_a, lat_b, lat_n);
                    outstanding         = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (mul_if.mul_start === 1'b1) begin
                start_total++;
                if (was_out) overlap_err++;
                lat_a       = mul_if.mul_a;
                lat_b       = mul_if.mul_b;
                lat_n       = mul_if.mul_n;
                outstanding = 1'b1;
                if (allow_big && $urandom_range(63, 0) == 0) lat_cnt = $urandom_range(300, 1) - 1;
                else lat_cnt = $urandom_range(max_lat, min_lat) - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] mode, input logic [MB-1:0] n,
                            input logic [MB-1:0] a, input logic [MB-1:0] e);
        @(negedge i_clk);
        i_mode  = mode;
        i_n     = n;
        i_a     = a;
        i_e     = e;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic scramble_inputs();
        i_mode = 2'($urandom_range(3, 0));
        for (int w = 0; w < MB / 32; w++) begin
            i_n[w*32 +: 32] = $urandom;
            i_a[w*32 +: 32] = $urandom;
            i_e[w*32 +: 32] = $urandom;
        end
    endtask

    task automatic wait_done(input string tag, output bit got);
        got = 1'b0;
        for (int c = 0; c < 60000 && !got; c++) begin
            if (o_finished === 1'b1) got = 1'b1;
            else @(negedge i_clk);
        end
        check({tag, "_done_seen"}, MB'(got), MB'(1));
    endtask

    task automatic run_op(input string tag, input logic [1:0] mode, input logic [MB-1:0] n,
                          input logic [MB-1:0] a, input logic [MB-1:0] e,
                          output logic [MB-1:0] res, output int pulses);
        int s0, ov0, st0;
        bit got;
        s0  = start_total;
        ov0 = overlap_err;
        st0 = stable_err;
        start_op(mode, n, a, e);
        check({tag, "_busy"}, MB'(o_busy), MB'(1));
        scramble_inputs();
        wait_done(tag, got);
        res    = o_result;
        pulses = start_total - s0;
        if (got) begin
            check({tag, "_busy_at_done"}, MB'(o_busy), MB'(0));
            @(negedge i_clk);
            check({tag, "_fin_one_cycle"}, MB'(o_finished), MB'(0));
            check({tag, "_result_held"}, o_result, res);
        end
        check({tag, "_no_overlap"}, MB'(overlap_err - ov0), MB'(0));
        check({tag, "_stable_ops"}, MB'(stable_err - st0), MB'(0));
    endtask

    initial begin
        logic [MB-1:0] res, p, n64, a64, e64;
        int            pulses, s0, seen;
        bit            got;

        repeat (3) @(negedge i_clk);
        check("rst_result", o_result, '0);
        check("rst_busy", MB'(o_busy), MB'(0));
        check("rst_finished", MB'(o_finished), MB'(0));
        check("rst_mul_start", MB'(mul_if.mul_start), MB'(0));
        i_rst = 1'b1;

        run_op("e3", 2'b00, 23, 5, 3, res, pulses);
        check("e3_result", res, 10);
        check("e3_pulses", MB'(pulses), MB'(33));

        run_op("fermat", 2'b00, 23, 5, 21, res, pulses);
        check("fermat_result", res, 14);
        check("fermat_inverse", mulmod(res, 5, 23), MB'(1));

        run_op("e0", 2'b00, 23, 7, 0, res, pulses);
        check("e0_result", res, 1);
        check("e0_pulses", MB'(pulses), MB'(31));

        run_op("n1", 2'b00, 1, 0, 5, res, pulses);
        check("n1_result", res, 0);

        run_op("upper_e", 2'b00, 23, 5, 64'hFFFF_FFFF_0000_0003, res, pulses);
        check("upper_e_result", res, 10);
        check("upper_e_pulses", MB'(pulses), MB'(33));

        p = MB'(1);
        p = (p << 255) - MB'(19);
        run_op("p25519", 2'b11, p, 2, p - MB'(2), res, pulses);
        check("p25519_result", res, (p + MB'(1)) >> 1);
        check("p25519_pulses", MB'(pulses), MB'(255 + $countones(p - MB'(2))));

        // Second start while the first multiply is outstanding must be dropped.
        min_lat = 20;
        max_lat = 20;
        s0 = start_total;
        start_op(2'b00, 23, 5, 3);
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            if (start_total > s0) seen = 1;
            else @(negedge i_clk);
        end
        check("restart_first_mul", MB'(seen), MB'(1));
        repeat (3) @(negedge i_clk);
        start_op(2'b01, 29, 3, 7);
        wait_done("restart", got);
        check("restart_result", o_result, 10);
        check("restart_pulses", MB'(start_total - s0), MB'(33));

        // Asynchronous reset in the middle of the first square.
        s0 = start_total;
        start_op(2'b00, 23, 5, 3);
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            if (start_total >= s0 + 2) seen = 1;
            else @(negedge i_clk);
        end
        check("rst_mid_sqr_reached", MB'(seen), MB'(1));
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        check("rst_mid_result", o_result, '0);
        check("rst_mid_busy", MB'(o_busy), MB'(0));
        check("rst_mid_finished", MB'(o_finished), MB'(0));
        check("rst_mid_mul_start", MB'(mul_if.mul_start), MB'(0));
        check("rst_mid_mul_a", mul_if.mul_a, '0);
        @(negedge i_clk);
        i_rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            if (o_finished === 1'b1 || o_busy === 1'b1) seen = 1;
        end
        check("rst_mid_quiet", MB'(seen), MB'(0));
        min_lat = 1;
        max_lat = 3;
        run_op("after_rst", 2'b00, 23, 5, 21, res, pulses);
        check("after_rst_result", res, 14);

        // Randomized 64-bit cases with occasional long multiplier latency.
        allow_big = 1'b1;
        for (int t = 0; t < 40; t++) begin
            n64 = '0;
            a64 = '0;
            n64[63:0] = {$urandom, $urandom};
            if (t % 8 == 0) n64[63:32] = '0;
            if (n64 == '0) n64 = MB'(1);
            a64[63:0] = {$urandom, $urandom};
            a64 = a64 % n64;
            for (int w = 0; w < MB / 32; w++) e64[w*32 +: 32] = $urandom;
            run_op("rand64", 2'b01, n64, a64, e64, res, pulses);
            check("rand64_result", res, modexp(n64, a64, e64, 63));
            check("rand64_pulses", MB'(pulses), MB'(63 + $countones(e64[63:0])));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
